// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//
// Groups every handshake and bus signal around the unified-memory arbiter:
// the fetch requester (if_*), the load/store requester (d_*) and the single
// memory port (mem_*).
//
// Modports:
//   slave  - the arbiter's view: takes requests from fetch/LSU and memory
//            responses, drives grants, responses and the memory command.
//   master - the surrounding system's view (core fetch/LSU plus memory
//            model): the mirror image of slave.
interface mem_port_arbiter_if;
    // Fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    // Load/store requester
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    // Memory port
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_addr, d_we, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_addr, d_we, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port memory between instruction fetch and load/store.
// One transaction is outstanding at a time. Data has priority over fetch,
// but after STARVE_LIMIT consecutive data grants with fetch waiting, fetch
// is served next. A watchdog ends any transaction the memory never answers
// after TIMEOUT cycles, returning an error response.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-high reset
//   bus_io - mem_port_arbiter_if.slave: fetch, data and memory signals
//            (grants and mem_* are combinational, responses are registered)
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus_io
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [15:0]     WAIT_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_D
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starveCnt_q, starveCnt_d;
    logic [15:0]   waitCnt_q, waitCnt_d;
    logic          dWrite_q, dWrite_d;

    logic          ifRvalid_q, ifRvalid_d;
    logic [31:0]   ifRdata_q, ifRdata_d;
    logic          ifErr_q, ifErr_d;
    logic          dRvalid_q, dRvalid_d;
    logic [31:0]   dRdata_q, dRdata_d;
    logic          dErr_q, dErr_d;

    logic          grantIf;
    logic          grantD;

    // Fetch only beats a pending data request once data has been granted
    // STARVE_LIMIT times in a row while fetch was waiting.
    assign grantIf = bus_io.if_req && (!bus_io.d_req || (starveCnt_q == STARVE_MAX));
    assign grantD  = !grantIf && bus_io.d_req;

    // Next-state, arbitration and memory command. The wait counter is
    // loaded with 1 at the grant so it counts cycles since the grant; the
    // watchdog then answers exactly TIMEOUT cycles after the grant.
    // A memory response in the watchdog cycle takes precedence.
    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        waitCnt_d   = 16'd0;
        dWrite_d    = dWrite_q;
        ifRvalid_d  = 1'b0;
        ifRdata_d   = ifRdata_q;
        ifErr_d     = 1'b0;
        dRvalid_d   = 1'b0;
        dRdata_d    = dRdata_q;
        dErr_d      = 1'b0;

        bus_io.if_gnt    = 1'b0;
        bus_io.d_gnt     = 1'b0;
        bus_io.mem_req   = 1'b0;
        bus_io.mem_addr  = 32'd0;
        bus_io.mem_we    = 4'd0;
        bus_io.mem_wdata = 32'd0;

        case (state_q)
            IDLE: begin
                if (grantIf) begin
                    bus_io.if_gnt   = 1'b1;
                    bus_io.mem_req  = 1'b1;
                    bus_io.mem_addr = bus_io.if_addr;
                    starveCnt_d     = '0;
                    waitCnt_d       = 16'd1;
                    state_d         = WAIT_IF;
                end else if (grantD) begin
                    bus_io.d_gnt     = 1'b1;
                    bus_io.mem_req   = 1'b1;
                    bus_io.mem_addr  = bus_io.d_addr;
                    bus_io.mem_we    = bus_io.d_we;
                    bus_io.mem_wdata = bus_io.d_wdata;
                    if (!bus_io.if_req) begin
                        starveCnt_d = '0;
                    end else if (starveCnt_q != STARVE_MAX) begin
                        starveCnt_d = starveCnt_q + 1'b1;
                    end
                    dWrite_d  = |bus_io.d_we;
                    waitCnt_d = 16'd1;
                    state_d   = WAIT_D;
                end
            end
            WAIT_IF: begin
                waitCnt_d = waitCnt_q + 16'd1;
                if (bus_io.mem_rvalid || (waitCnt_q == WAIT_LAST)) begin
                    ifRvalid_d = 1'b1;
                    ifErr_d    = !bus_io.mem_rvalid;
                    ifRdata_d  = bus_io.mem_rvalid ? bus_io.mem_rdata : 32'd0;
                    state_d    = IDLE;
                end
            end
            WAIT_D: begin
                waitCnt_d = waitCnt_q + 16'd1;
                if (bus_io.mem_rvalid || (waitCnt_q == WAIT_LAST)) begin
                    dRvalid_d = 1'b1;
                    dErr_d    = !bus_io.mem_rvalid;
                    dRdata_d  = (bus_io.mem_rvalid && !dWrite_q) ? bus_io.mem_rdata : 32'd0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset silently drops any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starveCnt_q <= '0;
            waitCnt_q   <= 16'd0;
            dWrite_q    <= 1'b0;
            ifRvalid_q  <= 1'b0;
            ifRdata_q   <= 32'd0;
            ifErr_q     <= 1'b0;
            dRvalid_q   <= 1'b0;
            dRdata_q    <= 32'd0;
            dErr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            waitCnt_q   <= waitCnt_d;
            dWrite_q    <= dWrite_d;
            ifRvalid_q  <= ifRvalid_d;
            ifRdata_q   <= ifRdata_d;
            ifErr_q     <= ifErr_d;
            dRvalid_q   <= dRvalid_d;
            dRdata_q    <= dRdata_d;
            dErr_q      <= dErr_d;
        end
    end

    assign bus_io.if_rvalid = ifRvalid_q;
    assign bus_io.if_rdata  = ifRdata_q;
    assign bus_io.if_err    = ifErr_q;
    assign bus_io.d_rvalid  = dRvalid_q;
    assign bus_io.d_rdata   = dRdata_q;
    assign bus_io.d_err     = dErr_q;

endmodule
